omsp_perfcnt: RTL and testbench

- Parametrised multi-channel event/performance counter peripheral on the openMSP430 peripheral bus (per_addr/per_din/per_we/per_en/per_dout).
- It generalises the fixed timer/GPIO peripherals to NCH independent channels of width CNT_W, with per-channel level/edge mode, atomic snapshot, sticky overflow flags and an overflow interrupt.
- per_dout is OR-combined with the other peripheral outputs at the top level.
- irq drives a free maskable IRQ vector.

---
 rtl/omsp_perfcnt.sv | 173 +++++++++++++++++
 tb/tb_omsp_perfcnt.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_perfcnt.sv
// omsp_perfcnt: NCH-channel event counter on the openMSP430 peripheral bus.
// Latency: bus writes take effect on the next mclk edge; reads are combinational; irq lags OVF by one cycle.
// Backpressure: none, the peripheral bus always completes in one cycle.
//
// Ports:
//   mclk, reset_n        clock, asynchronous active-low reset
//   per_addr/per_din     word address and write data
//   per_en/per_we        access enable and byte write enables ([0] low, [1] high)
//   per_dout             read data, 0 when not selected or during a write
//   event_in[NCH-1:0]    event sources, synchronous to mclk
//   irq                  level overflow interrupt, |(OVF & IEN) registered
//   trig_start/trig_stop hardware GEN control, present only with PERFCNT_HWTRIG_EN
//
// Register words (per_addr[3:0]): 0 CTRL, 1 SNAP, 2 OVF, 3 IEN, 4 MODE,
// 8+2i shadow[i] low half, 9+2i shadow[i] high half.
// Optional feature macro: PERFCNT_HWTRIG_EN.
module omsp_perfcnt #(
  parameter logic [14:0] BASE_ADDR = 15'h0100,
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 32
) (
  input  logic           mclk,
  input  logic           reset_n,
  input  logic [13:0]    per_addr,
  input  logic [15:0]    per_din,
  input  logic           per_en,
  input  logic [1:0]     per_we,
  output logic [15:0]    per_dout,
  input  logic [NCH-1:0] event_in,
`ifdef PERFCNT_HWTRIG_EN
  input  logic           trig_start,
  input  logic           trig_stop,
`endif
  output logic           irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bus decode
  logic       sel, wr, rd;
  logic [3:0] idx;
  logic       wr_ctrl_lo, wr_ctrl_hi, wr_snap, wr_ovf, wr_ien, wr_mode, clr;

  assign sel        = per_en & (per_addr[13:4] == BASE_ADDR[14:5]);
  assign wr         = sel & (|per_we);
  assign rd         = sel & ~(|per_we);
  assign idx        = per_addr[3:0];
  assign wr_ctrl_lo = wr & (idx == 4'd0) & per_we[0];
  assign wr_ctrl_hi = wr & (idx == 4'd0) & per_we[1];
  assign wr_snap    = wr & (idx == 4'd1);
  assign wr_ovf     = wr & (idx == 4'd2) & per_we[0];
  assign wr_ien     = wr & (idx == 4'd3) & per_we[0];
  assign wr_mode    = wr & (idx == 4'd4) & per_we[0];
  // CLR is a strobe only; it is never stored.
  assign clr        = wr_ctrl_lo & per_din[1];

  // Most data bits are don't-care for the narrow registers.
  logic unused_din;
  assign unused_din = ^per_din;

  // State
  logic                      gen_q, gen_d;
  logic [NCH-1:0]            chen_q, chen_d;
  logic [NCH-1:0]            ovf_q, ovf_d, ovf_set;
  logic [NCH-1:0]            ien_q, ien_d;
  logic [NCH-1:0]            mode_q, mode_d;
  logic [NCH-1:0]            prev_q;
  logic                      irq_q, irq_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CNT_W-1:0] shd_q, shd_d;

  // Edge-mode channels only count the cycle where event_in rises.
  logic [NCH-1:0] qual, inc;
  assign qual = event_in & ~(mode_q & prev_q);
  assign inc  = {NCH{gen_q}} & chen_q & qual;

  // GEN: hardware triggers first, a bus write in the same cycle overrides them.
  always_comb begin
    gen_d = gen_q;
`ifdef PERFCNT_HWTRIG_EN
    if (trig_stop) begin
      gen_d = 1'b0;
    end else if (trig_start) begin
      gen_d = 1'b1;
    end
`endif
    if (wr_ctrl_lo) begin
      gen_d = per_din[0];
    end
  end

  // Counters and shadows. SNAP samples the pre-increment value.
  always_comb begin
    cnt_d   = cnt_q;
    shd_d   = shd_q;
    ovf_set = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_snap) begin
        shd_d[i] = cnt_q[i];
      end
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc[i]) begin
        cnt_d[i]   = cnt_q[i] + CNT_ONE;
        ovf_set[i] = &cnt_q[i];
      end
    end
  end

  always_comb begin
    chen_d = wr_ctrl_hi ? per_din[8 +: NCH]   : chen_q;
    ien_d  = wr_ien     ? per_din[NCH-1:0]    : ien_q;
    mode_d = wr_mode    ? per_din[NCH-1:0]    : mode_q;
    // Clear first, then set, so a same-cycle overflow survives W1C.
    ovf_d  = (ovf_q & ~(wr_ovf ? per_din[NCH-1:0] : {NCH{1'b0}})) | ovf_set;
    irq_d  = |(ovf_q & ien_q);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      gen_q  <= 1'b0;
      chen_q <= '0;
      ovf_q  <= '0;
      ien_q  <= '0;
      mode_q <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
      cnt_q  <= '0;
      shd_q  <= '0;
    end else begin
      gen_q  <= gen_d;
      chen_q <= chen_d;
      ovf_q  <= ovf_d;
      ien_q  <= ien_d;
      mode_q <= mode_d;
      prev_q <= event_in;
      irq_q  <= irq_d;
      cnt_q  <= cnt_d;
      shd_q  <= shd_d;
    end
  end

  assign irq = irq_q;

  // Read mux. Shadows are zero-extended to 32 bits so the high half reads 0 when CNT_W=16.
  logic [15:0] rdata;
  logic [31:0] sh32;
  always_comb begin
    rdata = '0;
    sh32  = '0;
    case (idx)
      4'd0: begin
        rdata[0]         = gen_q;
        rdata[8 +: NCH]  = chen_q;
      end
      4'd2:    rdata[NCH-1:0] = ovf_q;
      4'd3:    rdata[NCH-1:0] = ien_q;
      4'd4:    rdata[NCH-1:0] = mode_q;
      default: begin
        if (idx[3]) begin
          for (int i = 0; i < NCH; i++) begin
            if (idx[2:1] == 2'(i)) begin
              sh32 = 32'(shd_q[i]);
            end
          end
          rdata = idx[0] ? sh32[31:16] : sh32[15:0];
        end
      end
    endcase
    per_dout = rd ? rdata : 16'h0000;
  end

endmodule

// File: tb/tb_omsp_perfcnt.sv
module tb_omsp_perfcnt;

  localparam logic [14:0] BASE   = 15'h0100;
  localparam logic [14:0] BASE16 = 15'h0200;
  localparam logic [14:0] BASEX  = 15'h0300;

  logic        mclk    = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din  = '0;
  logic        per_en   = 1'b0;
  logic [1:0]  per_we   = '0;
  logic [3:0]  event_in = '0;
  logic [15:0] dout_a, dout_b;
  logic        irq_a, irq_b;
  logic [3:0]  ev_hold = '0;
`ifdef PERFCNT_HWTRIG_EN
  logic        trig_start = 1'b0;
  logic        trig_stop  = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 mclk = ~mclk;

  omsp_perfcnt #(.BASE_ADDR(BASE), .NCH(4), .CNT_W(32)) u_dut (
    .mclk(mclk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(dout_a), .event_in(event_in),
`ifdef PERFCNT_HWTRIG_EN
    .trig_start(trig_start), .trig_stop(trig_stop),
`endif
    .irq(irq_a)
  );

  omsp_perfcnt #(.BASE_ADDR(BASE16), .NCH(2), .CNT_W(16)) u_dut16 (
    .mclk(mclk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(dout_b), .event_in(event_in[1:0]),
`ifdef PERFCNT_HWTRIG_EN
    .trig_start(1'b0), .trig_stop(1'b0),
`endif
    .irq(irq_b)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: inputs change at the falling edge, the DUT samples them at the next rising edge.
  task automatic cyc(input bit en, input logic [14:0] base, input logic [4:0] off,
                     input logic [1:0] we, input logic [15:0] din, input logic [3:0] ev);
    logic [14:0] a;
    @(negedge mclk);
    a        = base + {10'b0, off};
    per_en   = en;
    per_addr = a[14:1];
    per_we   = we;
    per_din  = din;
    event_in = ev;
  endtask

  task automatic idle(input int n, input logic [3:0] ev);
    repeat (n) cyc(1'b0, BASE, 5'd0, 2'b00, 16'h0000, ev);
  endtask

  task automatic wr(input logic [14:0] base, input logic [4:0] off,
                    input logic [1:0] we, input logic [15:0] din);
    cyc(1'b1, base, off, we, din, ev_hold);
    cyc(1'b0, base, off, 2'b00, 16'h0000, ev_hold);
  endtask

  // Peripheral outputs are OR-combined, as at the top level.
  task automatic rd(input logic [14:0] base, input logic [4:0] off, output logic [15:0] d);
    cyc(1'b1, base, off, 2'b00, 16'h0000, ev_hold);
    #1;
    d = dout_a | dout_b;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    per_en   = 1'b0;
    per_we   = 2'b00;
    event_in = '0;
    ev_hold  = '0;
`ifdef PERFCNT_HWTRIG_EN
    trig_start = 1'b0;
    trig_stop  = 1'b0;
`endif
    repeat (2) @(negedge mclk);
    reset_n = 1'b1;
  endtask

  // Behavioural reference for the NCH=4, CNT_W=32 instance.
  bit              m_gen, m_irq;
  bit [3:0]        m_chen, m_ovf, m_ien, m_mode, m_prev;
  longint unsigned m_cnt[4];
  longint unsigned m_sh[4];

  task automatic m_reset();
    m_gen = 0; m_irq = 0; m_chen = 0; m_ovf = 0; m_ien = 0; m_mode = 0; m_prev = 0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0;
      m_sh[i]  = 0;
    end
  endtask

  function automatic logic [15:0] m_read(input int w);
    int ch;
    case (w)
      0:       return {4'h0, m_chen, 7'h00, m_gen};
      2:       return {12'h000, m_ovf};
      3:       return {12'h000, m_ien};
      4:       return {12'h000, m_mode};
      default: begin
        if (w < 8) return 16'h0000;
        ch = (w - 8) / 2;
        if (w % 2 == 1) return 16'((m_sh[ch] >> 16) & 64'hFFFF);
        return 16'(m_sh[ch] & 64'hFFFF);
      end
    endcase
  endfunction

  task automatic m_step(input bit sel, input int w, input logic [1:0] we,
                        input logic [15:0] din, input logic [3:0] ev);
    bit       is_wr, is_clr, qual;
    bit [3:0] inc, setb;
    is_wr  = sel && (we != 2'b00);
    is_clr = is_wr && w == 0 && we[0] && din[1];
    setb   = 0;
    for (int i = 0; i < 4; i++) begin
      qual   = m_mode[i] ? (ev[i] && !m_prev[i]) : ev[i];
      inc[i] = m_gen && m_chen[i] && qual;
    end
    m_irq = |(m_ovf & m_ien);
    for (int i = 0; i < 4; i++) begin
      if (is_wr && w == 1) m_sh[i] = m_cnt[i];
      if (is_clr) m_cnt[i] = 0;
      else if (inc[i]) begin
        m_cnt[i] = (m_cnt[i] + 1) % (64'd1 << 32);
        if (m_cnt[i] == 0) setb[i] = 1;
      end
    end
    if (is_wr && w == 2 && we[0]) m_ovf = m_ovf & ~din[3:0];
    m_ovf = m_ovf | setb;
    if (is_wr && w == 0 && we[0]) m_gen  = din[0];
    if (is_wr && w == 0 && we[1]) m_chen = din[11:8];
    if (is_wr && w == 3 && we[0]) m_ien  = din[3:0];
    if (is_wr && w == 4 && we[0]) m_mode = din[3:0];
    m_prev = ev;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  off;
    logic [1:0]  we;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;

    // Reset: every offset of both windows reads 0, irq low.
    do_reset();
    for (int o = 0; o < 32; o += 2) begin
      rd(BASE, 5'(o), d);
      chk($sformatf("rst_rd_%02h", o), d, 16'h0000);
      rd(BASE16, 5'(o), d);
      chk($sformatf("rst16_rd_%02h", o), d, 16'h0000);
    end
    chk("rst_irq", {15'h0, irq_a}, 16'h0000);
    chk("rst_irq16", {15'h0, irq_b}, 16'h0000);

    // Register access vectors.
    tbl[0]  = '{1'b1, 5'h00, 2'b11, 16'h0F03, 16'h0000};
    tbl[1]  = '{1'b0, 5'h00, 2'b00, 16'h0000, 16'h0F01};
    tbl[2]  = '{1'b1, 5'h00, 2'b10, 16'h0500, 16'h0000};
    tbl[3]  = '{1'b0, 5'h00, 2'b00, 16'h0000, 16'h0501};
    tbl[4]  = '{1'b1, 5'h00, 2'b01, 16'hFF00, 16'h0000};
    tbl[5]  = '{1'b0, 5'h00, 2'b00, 16'h0000, 16'h0500};
    tbl[6]  = '{1'b1, 5'h06, 2'b11, 16'hFFFF, 16'h0000};
    tbl[7]  = '{1'b0, 5'h06, 2'b00, 16'h0000, 16'h000F};
    tbl[8]  = '{1'b1, 5'h08, 2'b10, 16'hFFFF, 16'h0000};
    tbl[9]  = '{1'b0, 5'h08, 2'b00, 16'h0000, 16'h0000};
    tbl[10] = '{1'b1, 5'h08, 2'b01, 16'h00A5, 16'h0000};
    tbl[11] = '{1'b0, 5'h08, 2'b00, 16'h0000, 16'h0005};
    tbl[12] = '{1'b0, 5'h04, 2'b00, 16'h0000, 16'h0000};
    tbl[13] = '{1'b0, 5'h02, 2'b00, 16'h0000, 16'h0000};
    tbl[14] = '{1'b1, 5'h0A, 2'b11, 16'hFFFF, 16'h0000};
    tbl[15] = '{1'b0, 5'h0A, 2'b00, 16'h0000, 16'h0000};
    tbl[16] = '{1'b1, 5'h1C, 2'b11, 16'hFFFF, 16'h0000};
    tbl[17] = '{1'b0, 5'h1C, 2'b00, 16'h0000, 16'h0000};
    for (int k = 0; k < NV; k++) begin
      if (tbl[k].wr) wr(BASE, tbl[k].off, tbl[k].we, tbl[k].din);
      else begin
        rd(BASE, tbl[k].off, d);
        chk($sformatf("vec%0d_off%02h", k, tbl[k].off), d, tbl[k].exp);
      end
    end

    // Level mode: 10 cycles of event_in[0].
    do_reset();
    wr(BASE, 5'h00, 2'b11, 16'h0F01);
    wr(BASE, 5'h08, 2'b11, 16'h0000);
    idle(10, 4'b0001);
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h10, d); chk("level_cnt", d, 16'h000A);

    // Edge mode: three 4-high/4-low pulses on channel 1.
    wr(BASE, 5'h08, 2'b11, 16'h0002);
    for (int p = 0; p < 3; p++) begin
      idle(4, 4'b0010);
      idle(4, 4'b0000);
    end
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h14, d); chk("edge_cnt", d, 16'h0003);
    rd(BASE, 5'h10, d); chk("ch0_hold", d, 16'h000A);
    rd(BASE, 5'h16, d); chk("ch1_hi", d, 16'h0000);

    // CLR together with a counted event: CLR wins, shadows untouched.
    cyc(1'b1, BASE, 5'h00, 2'b11, 16'h0F03, 4'b0001);
    idle(1, 4'b0000);
    rd(BASE, 5'h10, d); chk("clr_keeps_shadow", d, 16'h000A);
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h10, d); chk("clr_wins_ch0", d, 16'h0000);
    rd(BASE, 5'h14, d); chk("clr_wins_ch1", d, 16'h0000);

    // SNAP together with an increment captures the old value.
    idle(5, 4'b0001);
    cyc(1'b1, BASE, 5'h02, 2'b11, 16'h0000, 4'b0001);
    idle(1, 4'b0000);
    rd(BASE, 5'h10, d); chk("snap_pre_inc", d, 16'h0005);
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h10, d); chk("snap_post_inc", d, 16'h0006);

    // Clearing GEN: the event in the write cycle still counts.
    cyc(1'b1, BASE, 5'h00, 2'b11, 16'h0F00, 4'b0001);
    idle(3, 4'b0001);
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h10, d); chk("gen_off_late", d, 16'h0007);

    // High byte write leaves GEN alone; foreign window and write cycles read 0.
    wr(BASE, 5'h00, 2'b11, 16'h0F01);
    wr(BASE, 5'h00, 2'b10, 16'h0300);
    rd(BASE, 5'h00, d); chk("ctrl_hi_byte", d, 16'h0301);
    rd(BASEX, 5'h00, d); chk("other_window", d, 16'h0000);
    cyc(1'b1, BASE, 5'h00, 2'b01, 16'h0001, 4'b0000);
    #1; chk("dout_in_write", dout_a | dout_b, 16'h0000);

    // Asynchronous reset mid-count.
    idle(3, 4'b0001);
    #2;
    reset_n  = 1'b0;
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = BASE[14:1];
    #1; chk("arst_ctrl", dout_a, 16'h0000);
    per_addr = 14'((BASE + 15'h10) >> 1);
    #1; chk("arst_shadow", dout_a, 16'h0000);
    chk("arst_irq", {15'h0, irq_a}, 16'h0000);
    @(negedge mclk);
    reset_n = 1'b1; per_en = 1'b0; event_in = '0; ev_hold = '0;
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h10, d); chk("arst_cnt", d, 16'h0000);

    // 16-bit wrap on the second instance.
    wr(BASE16, 5'h06, 2'b11, 16'h0001);
    wr(BASE16, 5'h00, 2'b11, 16'h0301);
    idle(65536, 4'b0001);
    #1; chk("w16_no_irq_early", {15'h0, irq_b}, 16'h0000);
    idle(1, 4'b0001);
    #1; chk("w16_irq_lags_flag", {15'h0, irq_b}, 16'h0000);
    wr(BASE16, 5'h02, 2'b11, 16'h0000);
    rd(BASE16, 5'h10, d); chk("w16_shadow_lo", d, 16'h0001);
    rd(BASE16, 5'h12, d); chk("w16_shadow_hi", d, 16'h0000);
    rd(BASE16, 5'h04, d); chk("w16_ovf", d, 16'h0001);
    chk("w16_irq", {15'h0, irq_b}, 16'h0001);
    wr(BASE16, 5'h04, 2'b01, 16'h0001);
    #1; chk("w16_irq_still", {15'h0, irq_b}, 16'h0001);
    idle(1, 4'b0000);
    #1; chk("w16_irq_clr", {15'h0, irq_b}, 16'h0000);
    rd(BASE16, 5'h04, d); chk("w16_ovf_clr", d, 16'h0000);

`ifdef PERFCNT_HWTRIG_EN
    do_reset();
    wr(BASE, 5'h00, 2'b11, 16'h0100);
    @(negedge mclk); trig_start = 1'b1;
    @(negedge mclk); trig_start = 1'b0;
    idle(5, 4'b0001);
    @(negedge mclk); trig_stop = 1'b1; event_in = 4'b0000;
    @(negedge mclk); trig_stop = 1'b0;
    idle(3, 4'b0001);
    wr(BASE, 5'h02, 2'b11, 16'h0000);
    rd(BASE, 5'h10, d); chk("trig_cnt", d, 16'h0005);
    rd(BASE, 5'h00, d); chk("trig_stopped", d, 16'h0100);
    @(negedge mclk); trig_start = 1'b1;
    @(negedge mclk); trig_start = 1'b0;
    rd(BASE, 5'h00, d); chk("trig_started", d, 16'h0101);
    @(negedge mclk); trig_start = 1'b1; trig_stop = 1'b1;
    @(negedge mclk); trig_start = 1'b0; trig_stop = 1'b0;
    rd(BASE, 5'h00, d); chk("trig_both_stop", d, 16'h0100);
    cyc(1'b1, BASE, 5'h00, 2'b11, 16'h0101, 4'b0000);
    trig_stop = 1'b1;
    cyc(1'b0, BASE, 5'h00, 2'b00, 16'h0000, 4'b0000);
    trig_stop = 1'b0;
    rd(BASE, 5'h00, d); chk("trig_bus_override", d, 16'h0101);
`endif

    // Randomised traffic against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      int          kind, w;
      bit          en, sel;
      logic [14:0] base;
      logic [4:0]  off;
      logic [1:0]  we;
      logic [15:0] din, exp;
      logic [3:0]  ev;
      kind = $urandom_range(0, 99);
      off  = 5'(2 * $urandom_range(0, 15));
      ev   = 4'($urandom);
      din  = 16'($urandom);
      base = BASE; en = 1'b1; we = 2'b00;
      if (kind < 45) begin
      end else if (kind < 50) begin
        base = BASEX;
      end else if (kind < 55) begin
        en = 1'b0;
      end else begin
        we = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) off = 5'(2 * $urandom_range(0, 4));
        if (off == 5'h00 && $urandom_range(0, 3) != 0) din[1] = 1'b0;
      end
      cyc(en, base, off, we, din, ev);
      #1;
      sel = en && (base == BASE);
      w   = int'(off) / 2;
      exp = (sel && we == 2'b00) ? m_read(w) : 16'h0000;
      chk($sformatf("rand%0d_dout", n), dout_a | dout_b, exp);
      chk($sformatf("rand%0d_irq", n), {15'h0, irq_a}, {15'h0, m_irq});
      m_step(sel, w, we, din, ev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
